// File: rtl/flag_cross_arbiter_if.sv
// Handshake bundle between the requesters/crossing channel and the flag arbiter.
// The arbiter attaches through the slave modport; the surrounding logic uses master.
`timescale 1ns/1ps
interface flag_cross_arbiter_if #(
   parameter int N_REQ = 4,
   parameter int ID_W  = 2
);
   logic [N_REQ-1:0] req_clkA;
   logic [N_REQ-1:0] done_clkA;
   logic             FlagIn_clkA;
   logic             Busy_clkA;
   logic [ID_W-1:0]  chan_id_clkA;
   logic             active_clkA;
   logic             timeout_clkA;
   logic             clr_timeout_clkA;

   modport slave (
      input  req_clkA, Busy_clkA, clr_timeout_clkA,
      output done_clkA, FlagIn_clkA, chan_id_clkA, active_clkA, timeout_clkA
   );

   modport master (
      output req_clkA, Busy_clkA, clr_timeout_clkA,
      input  done_clkA, FlagIn_clkA, chan_id_clkA, active_clkA, timeout_clkA
   );
endinterface

// File: rtl/flag_cross_arbiter.sv
// Round-robin arbiter sharing one flag/ack crossing channel among N_REQ requesters,
// with a per-wait-state timeout that records a sticky error.
//
// state      | meaning
// IDLE       | arbitrate; launch only when a request is pending and Busy is low
// LAUNCH     | FlagIn pulse cycle
// WAIT_BUSY  | waiting for the channel to raise Busy
// WAIT_CLEAR | waiting for the channel to drop Busy
// DONE       | done pulse to the owner, no arbitration
`timescale 1ns/1ps
module flag_cross_arbiter #(
   parameter int N_REQ = 4,
   parameter int ID_W  = 2,
   parameter int TO_W  = 8
) (
   input  logic                  clkA,
   input  logic                  rstn_clkA,
   flag_cross_arbiter_if.slave   bus
);

   typedef enum logic [2:0] {
      IDLE       = 3'd0,
      LAUNCH     = 3'd1,
      WAIT_BUSY  = 3'd2,
      WAIT_CLEAR = 3'd3,
      DONE       = 3'd4
   } state_t;

   // Count value on which the next waiting cycle is the (2^TO_W-1)-th one.
   localparam logic [TO_W-1:0]  TO_LAST = TO_W'((1 << TO_W) - 2);
   localparam logic [N_REQ-1:0] ONE_HOT = N_REQ'(1);
   localparam logic [ID_W-1:0]  LAST_RST = ID_W'(N_REQ - 1);

   state_t          state;
   logic [ID_W-1:0] lastId;
   logic [TO_W-1:0] toCnt;
   logic [ID_W-1:0] winner;
   logic            anyReq;

   function automatic logic [ID_W-1:0] rrPick(input logic [N_REQ-1:0] req,
                                              input logic [ID_W-1:0]  prev);
      int              idx;
      logic [ID_W-1:0] pick;
      pick = prev;
      // Walk the offsets downward so the nearest set bit after prev is written last.
      for (int i = N_REQ; i >= 1; i--) begin
         idx = int'(prev) + i;
         if (idx >= N_REQ) idx = idx - N_REQ;
         if (req[idx]) pick = ID_W'(idx);
      end
      return pick;
   endfunction

   always_comb begin
      anyReq = |bus.req_clkA;
      winner = rrPick(bus.req_clkA, lastId);
   end

   always_ff @(posedge clkA or negedge rstn_clkA) begin
      if (!rstn_clkA) begin
         state            <= IDLE;
         lastId           <= LAST_RST;
         toCnt            <= '0;
         bus.FlagIn_clkA  <= 1'b0;
         bus.done_clkA    <= '0;
         bus.active_clkA  <= 1'b0;
         bus.timeout_clkA <= 1'b0;
         bus.chan_id_clkA <= '0;
      end else begin
         bus.FlagIn_clkA <= 1'b0;
         bus.done_clkA   <= '0;
         // A timeout raised below overrides this clear in the same cycle.
         if (bus.clr_timeout_clkA) bus.timeout_clkA <= 1'b0;

         unique case (state)
            IDLE: begin
               if (anyReq && !bus.Busy_clkA) begin
                  state            <= LAUNCH;
                  bus.FlagIn_clkA  <= 1'b1;
                  bus.active_clkA  <= 1'b1;
                  bus.chan_id_clkA <= winner;
                  lastId           <= winner;
               end
            end
            LAUNCH: begin
               state <= WAIT_BUSY;
               toCnt <= '0;
            end
            WAIT_BUSY: begin
               if (bus.Busy_clkA) begin
                  state <= WAIT_CLEAR;
                  toCnt <= '0;
               end else if (toCnt == TO_LAST) begin
                  state            <= IDLE;
                  bus.active_clkA  <= 1'b0;
                  bus.timeout_clkA <= 1'b1;
                  toCnt            <= '0;
               end else begin
                  toCnt <= toCnt + 1'b1;
               end
            end
            WAIT_CLEAR: begin
               if (!bus.Busy_clkA) begin
                  state         <= DONE;
                  bus.done_clkA <= ONE_HOT << bus.chan_id_clkA;
                  toCnt         <= '0;
               end else if (toCnt == TO_LAST) begin
                  state            <= IDLE;
                  bus.active_clkA  <= 1'b0;
                  bus.timeout_clkA <= 1'b1;
                  toCnt            <= '0;
               end else begin
                  toCnt <= toCnt + 1'b1;
               end
            end
            DONE: begin
               state           <= IDLE;
               bus.active_clkA <= 1'b0;
            end
            default: begin
               state           <= IDLE;
               bus.active_clkA <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_flag_cross_arbiter.sv
// Directed bench for flag_cross_arbiter: grant order, crossing handshake, timeouts, reset.
`timescale 1ns/1ps
module tb_flag_cross_arbiter;

   logic clkA;
   logic rstnClkA;
   int   checks;
   int   errors;
   logic [1:0] expChan;
   logic       expTmo;

   flag_cross_arbiter_if #(.N_REQ(4), .ID_W(2)) bus ();

   flag_cross_arbiter #(.N_REQ(4), .ID_W(2), .TO_W(4)) dut (
      .clkA      (clkA),
      .rstn_clkA (rstnClkA),
      .bus       (bus.slave)
   );

   initial clkA = 1'b0;
   always #5 clkA = ~clkA;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic expOut(input string tag, input logic f, input logic [3:0] d, input logic a);
      check({tag, ".flag"},    32'(bus.FlagIn_clkA),  32'(f));
      check({tag, ".done"},    32'(bus.done_clkA),    32'(d));
      check({tag, ".active"},  32'(bus.active_clkA),  32'(a));
      check({tag, ".chan"},    32'(bus.chan_id_clkA), 32'(expChan));
      check({tag, ".timeout"}, 32'(bus.timeout_clkA), 32'(expTmo));
   endtask

   task automatic tick();
      @(posedge clkA);
      #1;
   endtask

   // Full grant with a standard crossing: Busy rises one cycle after the pulse, held 6 cycles.
   task automatic serve(input logic [1:0] id, input logic [3:0] dropMask, input string tag);
      tick();
      expChan = id;
      expOut({tag, ".grant"}, 1'b1, 4'b0000, 1'b1);
      tick();
      expOut({tag, ".launch"}, 1'b0, 4'b0000, 1'b1);
      bus.Busy_clkA = 1'b1;
      repeat (6) begin
         tick();
         expOut({tag, ".busy"}, 1'b0, 4'b0000, 1'b1);
      end
      bus.Busy_clkA = 1'b0;
      tick();
      expOut({tag, ".done"}, 1'b0, 4'(1) << id, 1'b1);
      bus.req_clkA = bus.req_clkA & ~dropMask;
      tick();
      expOut({tag, ".idle"}, 1'b0, 4'b0000, 1'b0);
   endtask

   initial begin
      checks = 0;
      errors = 0;
      expChan = 2'd0;
      expTmo = 1'b0;
      rstnClkA = 1'b1;
      bus.req_clkA = 4'b0000;
      bus.Busy_clkA = 1'b0;
      bus.clr_timeout_clkA = 1'b0;

      #1 rstnClkA = 1'b0;
      #1 expOut("reset", 1'b0, 4'b0000, 1'b0);
      @(negedge clkA) rstnClkA = 1'b1;

      bus.req_clkA = 4'b0001;
      serve(2'd0, 4'b0001, "single");

      rstnClkA = 1'b0;
      #1 expOut("idle_reset", 1'b0, 4'b0000, 1'b0);
      @(negedge clkA) rstnClkA = 1'b1;

      bus.req_clkA = 4'b1111;
      serve(2'd0, 4'b0001, "rr0");
      serve(2'd1, 4'b0010, "rr1");
      serve(2'd2, 4'b0100, "rr2");
      serve(2'd3, 4'b1000, "rr3");
      bus.req_clkA = 4'b1010;
      serve(2'd1, 4'b0010, "rr_b1");
      serve(2'd3, 4'b1000, "rr_b3");

      bus.Busy_clkA = 1'b1;
      bus.req_clkA = 4'b0100;
      repeat (3) begin
         tick();
         expOut("stale_hold", 1'b0, 4'b0000, 1'b0);
      end
      bus.Busy_clkA = 1'b0;
      serve(2'd2, 4'b0100, "stale");

      bus.req_clkA = 4'b0001;
      tick();
      expChan = 2'd0;
      expOut("bto.grant", 1'b1, 4'b0000, 1'b1);
      bus.req_clkA = 4'b0000;
      tick();
      expOut("bto.launch", 1'b0, 4'b0000, 1'b1);
      repeat (14) begin
         tick();
         expOut("bto.wait", 1'b0, 4'b0000, 1'b1);
      end
      tick();
      expTmo = 1'b1;
      expOut("bto.fire", 1'b0, 4'b0000, 1'b0);
      tick();
      expOut("bto.sticky", 1'b0, 4'b0000, 1'b0);
      bus.clr_timeout_clkA = 1'b1;
      tick();
      expTmo = 1'b0;
      expOut("bto.clear", 1'b0, 4'b0000, 1'b0);
      bus.clr_timeout_clkA = 1'b0;

      bus.req_clkA = 4'b0010;
      tick();
      expChan = 2'd1;
      expOut("rto.grant", 1'b1, 4'b0000, 1'b1);
      bus.req_clkA = 4'b0000;
      tick();
      expOut("rto.launch", 1'b0, 4'b0000, 1'b1);
      bus.Busy_clkA = 1'b1;
      tick();
      expOut("rto.enter", 1'b0, 4'b0000, 1'b1);
      repeat (14) begin
         tick();
         expOut("rto.wait", 1'b0, 4'b0000, 1'b1);
      end
      bus.clr_timeout_clkA = 1'b1;
      tick();
      expTmo = 1'b1;
      expOut("rto.fire_with_clear", 1'b0, 4'b0000, 1'b0);
      bus.clr_timeout_clkA = 1'b0;
      bus.req_clkA = 4'b0100;
      repeat (3) begin
         tick();
         expOut("rto.holdoff", 1'b0, 4'b0000, 1'b0);
      end
      bus.Busy_clkA = 1'b0;
      serve(2'd2, 4'b0100, "rto.after");
      bus.clr_timeout_clkA = 1'b1;
      tick();
      expTmo = 1'b0;
      expOut("rto.clear", 1'b0, 4'b0000, 1'b0);
      bus.clr_timeout_clkA = 1'b0;

      bus.req_clkA = 4'b0010;
      tick();
      expChan = 2'd1;
      expOut("wd.grant", 1'b1, 4'b0000, 1'b1);
      tick();
      expOut("wd.launch", 1'b0, 4'b0000, 1'b1);
      bus.Busy_clkA = 1'b1;
      tick();
      expOut("wd.clear_wait", 1'b0, 4'b0000, 1'b1);
      bus.req_clkA = 4'b0000;
      tick();
      expOut("wd.withdrawn", 1'b0, 4'b0000, 1'b1);
      bus.Busy_clkA = 1'b0;
      tick();
      expOut("wd.done", 1'b0, 4'b0010, 1'b1);
      tick();
      expOut("wd.idle", 1'b0, 4'b0000, 1'b0);

      bus.req_clkA = 4'b0100;
      tick();
      expChan = 2'd2;
      expOut("mrst.grant", 1'b1, 4'b0000, 1'b1);
      bus.req_clkA = 4'b0000;
      tick();
      bus.Busy_clkA = 1'b1;
      tick();
      expOut("mrst.clear_wait", 1'b0, 4'b0000, 1'b1);
      #1 rstnClkA = 1'b0;
      #1 expChan = 2'd0;
      expOut("mrst.async", 1'b0, 4'b0000, 1'b0);
      bus.Busy_clkA = 1'b0;
      bus.req_clkA = 4'b1001;
      @(negedge clkA) rstnClkA = 1'b1;
      serve(2'd0, 4'b1001, "mrst.next");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
